// File: rtl/uart_package.sv
// Shared types and sizing helpers for the buffered UART transmitter.
// UART_TX_PARITY_EN selects whether a parity bit is part of each frame.
package uart_package;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; head word is readable combinationally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (count_r == CNT_MAX);
    assign empty   = (count_r == '0);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, back-to-back frames without idle gap.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_buffered
    import uart_package::*;
#(
    parameter int WAIT       = 100,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          parity_odd,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = cnt_width(WAIT);
    localparam int BIT_W  = cnt_width((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(WAIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t              state_r, state_s;
    logic [BAUD_W-1:0]      baud_r, baud_s;
    logic [BIT_W-1:0]       bit_r, bit_s;
    logic [DATA_BITS-1:0]   word_r;
    logic [DATA_BITS-1:0]   head_s;
    logic                   par_odd_r;
    logic                   tx_r, tx_s;
    logic                   busy_r;
    logic                   push_s, pop_s;
    logic                   full_s, empty_s;
    logic                   baud_end_s;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w, input logic odd);
        return (^w) ^ odd;
    endfunction
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_odd;
`endif

    assign in_ready   = ~full_s;
    assign push_s     = in_valid & ~full_s;
    assign uart_tx    = tx_r;
    assign busy       = busy_r;
    assign baud_end_s = (baud_r == BAUD_LAST);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push_s),
        .wr_data (in_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (fifo_count)
    );

    // Next state, counters and pop; every transition clears both counters.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_s = START;
                    pop_s   = 1'b1;
                    baud_s  = '0;
                    bit_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    state_s = DATA;
                    baud_s  = '0;
                    bit_s   = '0;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_end_s && (bit_r == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_s = PARITY;
`else
                    state_s = STOP;
`endif
                    baud_s  = '0;
                    bit_s   = '0;
                end else if (baud_end_s) begin
                    baud_s = '0;
                    bit_s  = bit_r + BIT_ONE;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end_s) begin
                    state_s = STOP;
                    baud_s  = '0;
                    bit_s   = '0;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_end_s && (bit_r == STOP_LAST)) begin
                    if (!empty_s) begin
                        state_s = START;
                        pop_s   = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                    baud_s = '0;
                    bit_s  = '0;
                end else if (baud_end_s) begin
                    baud_s = '0;
                    bit_s  = bit_r + BIT_ONE;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                bit_s   = '0;
            end
        endcase
    end

    // Line level for the coming cycle, derived from the next state so the pin is registered.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = word_r[bit_s];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = parity_bit(word_r, par_odd_r);
`endif
            STOP:    tx_s = 1'b1;
            IDLE:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State, counters, latched frame word and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            baud_r    <= '0;
            bit_r     <= '0;
            word_r    <= '0;
            par_odd_r <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            if (pop_s) begin
                word_r    <= head_s;
                par_odd_r <= parity_odd;
            end
            tx_r   <= tx_s;
            busy_r <= (state_s != IDLE);
        end
    end

endmodule
